seq_counter_ctrl: RTL and testbench

Controller that sequences the 3-bit T-flip-flop sequence counter (cycle 1→3→2→6→7→5→4→1) from the board pushbuttons and switches. It synchronises and edge-detects the active-low KEY inputs, and runs a prescaler that generates the advance rate from CLOCK_50. A small run/pause FSM issues load and single-step commands. It holds the authoritative count value that feeds the BCD/7-segment display path and strobes that mark every change.

---
 rtl/seq_counter_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_seq_counter_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_counter_ctrl.sv
// Run/pause/step/load controller for the 3-bit sequence counter 1-3-2-6-7-5-4.
// Optional key debounce compiled in with `define SEQ_CTRL_DEBOUNCE_EN.
module seq_counter_ctrl #(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       key_load_n,
    input  logic [2:0] load_val,
    output logic [2:0] count,
    output logic       running,
    output logic       step_pulse,
    output logic       load_pulse,
    output logic       illegal
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    keys_n;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    level;
    logic [2:0]    prev_q, ev_q;
    logic          ev_run, ev_step, ev_load;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          do_load, do_adv;
    logic [2:0]    count_q;
    logic          step_q, load_q, illegal_q;

    function automatic logic [2:0] next_seq(input logic [2:0] v);
        logic [2:0] n;
        case (v)
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b111;
            3'b111:  n = 3'b101;
            3'b101:  n = 3'b100;
            3'b100:  n = 3'b001;
            default: n = 3'b001;
        endcase
        return n;
    endfunction

    assign keys_n = {key_load_n, key_step_n, key_run_n};

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef SEQ_CTRL_DEBOUNCE_EN
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]     db_q, db_d;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            db_q <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign level = db_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            prev_q <= '1;
            ev_q   <= '0;
        end else begin
            prev_q <= level;
            ev_q   <= prev_q & ~level;
        end
    end

    assign ev_run  = ev_q[0];
    assign ev_step = ev_q[1];
    assign ev_load = ev_q[2];

    assign tick = (state_q == RUNNING) && (presc_q == PRESC_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ev_load && ev_run) begin
            case (state_q)
                PAUSED:  state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                default: state_d = PAUSED;
            endcase
        end
    end

    // Load beats run toggle beats step/tick; the prescaler restarts whenever it is not free-running.
    always_comb begin
        do_load = ev_load;
        do_adv  = 1'b0;
        presc_d = '0;
        case (state_q)
            PAUSED: begin
                if (!ev_load && !ev_run && ev_step) begin
                    do_adv = 1'b1;
                end
            end
            RUNNING: begin
                if (!ev_load && !ev_run) begin
                    if (tick) begin
                        do_adv = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            count_q   <= 3'b001;
            step_q    <= 1'b0;
            load_q    <= 1'b0;
            illegal_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            step_q  <= do_adv;
            load_q  <= do_load;
            presc_q <= presc_d;
            if (do_load) begin
                if (load_val == 3'b000) begin
                    count_q   <= 3'b001;
                    illegal_q <= 1'b1;
                end else begin
                    count_q   <= load_val;
                    illegal_q <= 1'b0;
                end
            end else if (do_adv) begin
                count_q <= next_seq(count_q);
            end
        end
    end

    assign count      = count_q;
    assign running    = (state_q == RUNNING);
    assign step_pulse = step_q;
    assign load_pulse = load_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed self-checking bench for seq_counter_ctrl (TICK_DIV=4, DEBOUNCE_CYCLES=8).
module tb_seq_counter_ctrl;

    localparam int unsigned TICK = 4;
`ifdef SEQ_CTRL_DEBOUNCE_EN
    localparam int unsigned KEY_LAT = 12;
`else
    localparam int unsigned KEY_LAT = 4;
`endif
    localparam int unsigned ALIGN = (TICK - (KEY_LAT % TICK)) % TICK;

    logic       CLOCK_50   = 1'b0;
    logic       RESET      = 1'b1;
    logic       key_run_n  = 1'b1;
    logic       key_step_n = 1'b1;
    logic       key_load_n = 1'b1;
    logic [2:0] load_val   = 3'b000;
    logic [2:0] count;
    logic       running, step_pulse, load_pulse, illegal;

    int checks = 0;
    int passed = 0;

    logic [2:0]  exp_cnt;
    logic        exp_run, exp_step, exp_load, exp_ill;
    int unsigned phase, pend_r, pend_s, pend_l;

    always #5 CLOCK_50 = ~CLOCK_50;

    seq_counter_ctrl #(
        .TICK_DIV(TICK),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .key_run_n(key_run_n),
        .key_step_n(key_step_n),
        .key_load_n(key_load_n),
        .load_val(load_val),
        .count(count),
        .running(running),
        .step_pulse(step_pulse),
        .load_pulse(load_pulse),
        .illegal(illegal)
    );

    function automatic logic [2:0] seq_next(input logic [2:0] v);
        case (v)
            3'b001:  return 3'b011;
            3'b011:  return 3'b010;
            3'b010:  return 3'b110;
            3'b110:  return 3'b111;
            3'b111:  return 3'b101;
            3'b101:  return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    function automatic void model_reset();
        exp_cnt  = 3'b001;
        exp_run  = 1'b0;
        exp_step = 1'b0;
        exp_load = 1'b0;
        exp_ill  = 1'b0;
        phase    = 0;
        pend_r   = 0;
        pend_s   = 0;
        pend_l   = 0;
    endfunction

    // Advances the expected state by one clock; pend_* count down to a key's event cycle.
    function automatic void model_step();
        logic el, er, es;
        el = 1'b0; er = 1'b0; es = 1'b0;
        if (RESET) begin
            model_reset();
            return;
        end
        if (pend_l != 0) begin pend_l--; el = (pend_l == 0); end
        if (pend_r != 0) begin pend_r--; er = (pend_r == 0); end
        if (pend_s != 0) begin pend_s--; es = (pend_s == 0); end
        exp_step = 1'b0;
        exp_load = 1'b0;
        if (el) begin
            exp_load = 1'b1;
            phase    = 0;
            if (load_val == 3'b000) begin
                exp_cnt = 3'b001;
                exp_ill = 1'b1;
            end else begin
                exp_cnt = load_val;
                exp_ill = 1'b0;
            end
        end else if (er) begin
            exp_run = !exp_run;
            phase   = 0;
        end else if (!exp_run) begin
            phase = 0;
            if (es) begin
                exp_step = 1'b1;
                exp_cnt  = seq_next(exp_cnt);
            end
        end else begin
            phase++;
            if (phase == TICK) begin
                phase    = 0;
                exp_step = 1'b1;
                exp_cnt  = seq_next(exp_cnt);
            end
        end
    endfunction

    function automatic logic [6:0] obs_v();
        return {count, running, step_pulse, load_pulse, illegal};
    endfunction

    function automatic logic [6:0] exp_v();
        return {exp_cnt, exp_run, exp_step, exp_load, exp_ill};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        RESET = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL reset_hold: got %b expected %b", obs_v(), exp_v());
            else passed++;
        end
        RESET = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL reset_idle c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (obs_v() !== 7'b001_0_0_0_0) $display("FAIL reset_state: got %b expected 0010000", obs_v());
        else passed++;
    endtask

    task automatic test_step_paused();
        logic [2:0] want [7];
        int pulses;
        want = '{3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b001};
        for (int p = 0; p < 7; p++) begin
            pulses     = 0;
            key_step_n = 1'b0;
            pend_s     = KEY_LAT;
            for (int c = 0; c < int'(2 * KEY_LAT + 2); c++) begin
                tick(); model_step();
                if (c == int'(KEY_LAT) - 1) key_step_n = 1'b1;
                pulses += int'(step_pulse);
                checks++;
                if (obs_v() !== exp_v()) $display("FAIL step_cycle p=%0d c=%0d: got %b expected %b", p, c, obs_v(), exp_v());
                else passed++;
            end
            checks++;
            if (pulses != 1 || count !== want[p])
                $display("FAIL step_press p=%0d: got count=%b pulses=%0d expected count=%b pulses=1", p, count, pulses, want[p]);
            else passed++;
        end
    endtask

    task automatic test_run();
        int pulses;
        key_run_n = 1'b0;
        pend_r    = KEY_LAT;
        for (int c = 0; c < int'(KEY_LAT); c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) key_run_n = 1'b1;
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL run_press c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (running !== 1'b1 || step_pulse !== 1'b0) $display("FAIL run_enter: got running=%b step=%b expected 1 0", running, step_pulse);
        else passed++;
        pulses = 0;
        for (int c = 0; c < 28; c++) begin
            tick(); model_step();
            pulses += int'(step_pulse);
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL run_walk c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (pulses != 7 || count !== 3'b001) $display("FAIL run_wrap: got pulses=%0d count=%b expected 7 001", pulses, count);
        else passed++;
        pulses     = 0;
        key_step_n = 1'b0;
        pend_s     = KEY_LAT;
        for (int c = 0; c < 20; c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) key_step_n = 1'b1;
            pulses += int'(step_pulse);
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL run_step_ignored c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (pulses != 5) $display("FAIL run_step_count: got pulses=%0d expected 5", pulses);
        else passed++;
    endtask

    task automatic test_load();
        logic [2:0] vals [3];
        logic [6:0] want [3];
        vals = '{3'b110, 3'b000, 3'b101};
        want = '{7'b110_1_0_1_0, 7'b001_1_0_1_1, 7'b101_1_0_1_0};
        for (int v = 0; v < 3; v++) begin
            load_val   = vals[v];
            key_load_n = 1'b0;
            pend_l     = KEY_LAT;
            for (int c = 0; c < int'(KEY_LAT); c++) begin
                tick(); model_step();
                if (c == int'(KEY_LAT) - 1) key_load_n = 1'b1;
                checks++;
                if (obs_v() !== exp_v()) $display("FAIL load_press v=%0d c=%0d: got %b expected %b", v, c, obs_v(), exp_v());
                else passed++;
            end
            checks++;
            if (obs_v() !== want[v]) $display("FAIL load_result v=%0d: got %b expected %b", v, obs_v(), want[v]);
            else passed++;
            for (int c = 0; c < int'(TICK); c++) begin
                tick(); model_step();
                checks++;
                if (obs_v() !== exp_v()) $display("FAIL load_after v=%0d c=%0d: got %b expected %b", v, c, obs_v(), exp_v());
                else passed++;
            end
            if (v == 0) begin
                checks++;
                if (step_pulse !== 1'b1 || count !== 3'b111) $display("FAIL load_next_adv: got step=%b count=%b expected 1 111", step_pulse, count);
                else passed++;
            end
            for (int c = 0; c < int'(KEY_LAT + 2); c++) begin
                tick(); model_step();
                checks++;
                if (obs_v() !== exp_v()) $display("FAIL load_idle v=%0d c=%0d: got %b expected %b", v, c, obs_v(), exp_v());
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        load_val   = 3'b111;
        key_load_n = 1'b0;
        key_run_n  = 1'b0;
        pend_l     = KEY_LAT;
        pend_r     = KEY_LAT;
        for (int c = 0; c < int'(KEY_LAT); c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) begin key_load_n = 1'b1; key_run_n = 1'b1; end
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL simul_press c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (obs_v() !== 7'b111_1_0_1_0) $display("FAIL simul_load_run: got %b expected 1111010", obs_v());
        else passed++;
        for (int c = 0; c < int'(KEY_LAT + 2); c++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL simul_idle c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        for (int g = 0; g < int'(TICK) && phase != ALIGN; g++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL align c=%0d: got %b expected %b", g, obs_v(), exp_v());
            else passed++;
        end
        pulses    = 0;
        key_run_n = 1'b0;
        pend_r    = KEY_LAT;
        for (int c = 0; c < int'(KEY_LAT); c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) key_run_n = 1'b1;
            pulses += int'(step_pulse);
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL run_vs_tick c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (running !== 1'b0 || step_pulse !== 1'b0 || pulses != int'(KEY_LAT / TICK) - 1)
            $display("FAIL run_vs_tick_result: got running=%b step=%b pulses=%0d expected 0 0 %0d",
                     running, step_pulse, pulses, int'(KEY_LAT / TICK) - 1);
        else passed++;
        for (int c = 0; c < int'(KEY_LAT + 2); c++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL paused_hold c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        key_run_n = 1'b0;
        pend_r    = KEY_LAT;
        for (int c = 0; c < int'(KEY_LAT + 6); c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) key_run_n = 1'b1;
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL resume c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        RESET = 1'b1;
        tick(); model_step();
        checks++;
        if (obs_v() !== 7'b001_0_0_0_0) $display("FAIL reset_midrun: got %b expected 0010000", obs_v());
        else passed++;
        RESET = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); model_step();
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL post_reset c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
    endtask

`ifdef SEQ_CTRL_DEBOUNCE_EN
    task automatic test_debounce();
        int pulses;
        pulses     = 0;
        key_step_n = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick(); model_step();
            if (c == 4) key_step_n = 1'b1;
            pulses += int'(step_pulse);
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL glitch c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (pulses != 0) $display("FAIL glitch_count: got pulses=%0d expected 0", pulses);
        else passed++;
        key_step_n = 1'b0;
        pend_s     = KEY_LAT;
        for (int c = 0; c < int'(2 * KEY_LAT + 2); c++) begin
            tick(); model_step();
            if (c == int'(KEY_LAT) - 1) key_step_n = 1'b1;
            pulses += int'(step_pulse);
            checks++;
            if (obs_v() !== exp_v()) $display("FAIL db_press c=%0d: got %b expected %b", c, obs_v(), exp_v());
            else passed++;
        end
        checks++;
        if (pulses != 1 || count !== 3'b011) $display("FAIL db_press_count: got pulses=%0d count=%b expected 1 011", pulses, count);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_step_paused();
        test_run();
        test_load();
        test_back_to_back();
`ifdef SEQ_CTRL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
